// File: rtl/regfile_mp.sv
// Multi-port integer register file with asynchronous reads, synchronous writes,
// optional write-to-read bypass and a pending-write busy scoreboard for RAW stalls.
module regfile_mp #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NR_REGS  = 32,
  parameter int unsigned NR_READ  = 2,
  parameter int unsigned NR_WRITE = 1,
  parameter int unsigned BYPASS   = 0,
  localparam int unsigned ADDR_W  = $clog2(NR_REGS)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NR_READ*ADDR_W-1:0]    rs_addr_i,
  output logic [NR_READ*DATA_W-1:0]    rs_data_o,
  output logic [NR_READ-1:0]           rs_busy_o,
  input  logic [NR_WRITE*ADDR_W-1:0]   rd_addr_i,
  input  logic [NR_WRITE*DATA_W-1:0]   rd_data_i,
  input  logic [NR_WRITE-1:0]          rd_we_i,
  input  logic                         sb_set_i,
  input  logic [ADDR_W-1:0]            sb_addr_i,
  output logic [ADDR_W:0]              busy_cnt_o
);

  function automatic logic [ADDR_W:0] popcount(input logic [NR_REGS-1:0] v);
    logic [ADDR_W:0] c;
    c = '0;
    for (int i = 0; i < NR_REGS; i++) begin
      c = c + {{ADDR_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic [DATA_W-1:0]  regs_p0 [NR_REGS];
  logic [DATA_W-1:0]  regs_d  [NR_REGS];
  logic [NR_REGS-1:0] busy_p0;
  logic [NR_REGS-1:0] busy_d;

  // Next state: later write ports override earlier ones; an issue set overrides a writeback clear.
  always_comb begin
    for (int r = 0; r < NR_REGS; r++) begin
      regs_d[r] = regs_p0[r];
    end
    busy_d = busy_p0;
    for (int w = 0; w < NR_WRITE; w++) begin
      if (rd_we_i[w]) begin
        regs_d[rd_addr_i[w*ADDR_W +: ADDR_W]] = rd_data_i[w*DATA_W +: DATA_W];
        busy_d[rd_addr_i[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (sb_set_i) begin
      busy_d[sb_addr_i] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // Stage p0: architectural state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < NR_REGS; r++) begin
        regs_p0[r] <= '0;
      end
      busy_p0 <= '0;
    end else begin
      for (int r = 0; r < NR_REGS; r++) begin
        regs_p0[r] <= regs_d[r];
      end
      busy_p0 <= busy_d;
    end
  end

  for (genvar p = 0; p < NR_READ; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = rs_addr_i[p*ADDR_W +: ADDR_W];

    always_comb begin
      rd = regs_p0[ra];
      if (BYPASS != 0) begin
        for (int w = 0; w < NR_WRITE; w++) begin
          if (rd_we_i[w] && (rd_addr_i[w*ADDR_W +: ADDR_W] == ra)) begin
            rd = rd_data_i[w*DATA_W +: DATA_W];
          end
        end
      end
      if (ra == '0) begin
        rd = '0;
      end
    end

    assign rs_data_o[p*DATA_W +: DATA_W] = rd;
    assign rs_busy_o[p]                  = busy_p0[ra];
  end

  assign busy_cnt_o = popcount(busy_p0);

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised scoreboard bench for regfile_mp: a BYPASS=0 and a BYPASS=1 instance share stimulus.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic [2*AW-1:0] rs_addr;
  logic [2*DW-1:0] rs_data_nb, rs_data_by;
  logic [1:0]      busy_nb, busy_by;
  logic [2*AW-1:0] rd_addr;
  logic [2*DW-1:0] rd_data;
  logic [1:0]      rd_we;
  logic            sb_set;
  logic [AW-1:0]   sb_addr;
  logic [AW:0]     cnt_nb, cnt_by;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DW), .NR_REGS(NR), .NR_READ(2), .NR_WRITE(2), .BYPASS(0)) u_nb (
    .clk_i(clk), .rst_ni(rst_ni), .rs_addr_i(rs_addr), .rs_data_o(rs_data_nb),
    .rs_busy_o(busy_nb), .rd_addr_i(rd_addr), .rd_data_i(rd_data), .rd_we_i(rd_we),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .busy_cnt_o(cnt_nb));

  regfile_mp #(.DATA_W(DW), .NR_REGS(NR), .NR_READ(2), .NR_WRITE(2), .BYPASS(1)) u_by (
    .clk_i(clk), .rst_ni(rst_ni), .rs_addr_i(rs_addr), .rs_data_o(rs_data_by),
    .rs_busy_o(busy_by), .rd_addr_i(rd_addr), .rd_data_i(rd_data), .rd_we_i(rd_we),
    .sb_set_i(sb_set), .sb_addr_i(sb_addr), .busy_cnt_o(cnt_by));

  typedef struct {
    logic [31:0] nb0, nb1, by0, by1;
    logic [1:0]  busy;
    logic [5:0]  cnt;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem[NR];
  bit          bsy[NR];
  int          n_chk = 0;
  int          n_pass = 0;

  function automatic logic [31:0] rd_model(int a, bit byp, bit [1:0] we,
                                           int wa0, logic [31:0] wd0, int wa1, logic [31:0] wd1);
    logic [31:0] v;
    if (a == 0) return 32'h0;
    v = mem[a];
    if (byp) begin
      if (we[0] && wa0 == a) v = wd0;
      if (we[1] && wa1 == a) v = wd1;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // One cycle of stimulus; the expected outputs for this cycle go to the scoreboard queue.
  task automatic step(input bit rst_v, input int ra0, input int ra1, input bit [1:0] we,
                      input int wa0, input logic [31:0] wd0, input int wa1, input logic [31:0] wd1,
                      input bit set, input int sa);
    exp_t e;
    int   c;
    @(posedge clk);
    #1;
    rs_addr = {5'(ra1), 5'(ra0)};
    rd_addr = {5'(wa1), 5'(wa0)};
    rd_data = {wd1, wd0};
    rd_we   = we;
    sb_set  = set;
    sb_addr = 5'(sa);
    rst_ni  = rst_v;
    if (!rst_v) begin
      for (int i = 0; i < NR; i++) begin
        mem[i] = 32'h0;
        bsy[i] = 1'b0;
      end
    end
    e.nb0  = rd_model(ra0, 1'b0, we, wa0, wd0, wa1, wd1);
    e.nb1  = rd_model(ra1, 1'b0, we, wa0, wd0, wa1, wd1);
    e.by0  = rd_model(ra0, 1'b1, we, wa0, wd0, wa1, wd1);
    e.by1  = rd_model(ra1, 1'b1, we, wa0, wd0, wa1, wd1);
    e.busy = {bsy[ra1], bsy[ra0]};
    c = 0;
    for (int i = 0; i < NR; i++) c += int'(bsy[i]);
    e.cnt = 6'(c);
    sb_q.push_back(e);
    if (rst_v) begin
      if (we[0] && wa0 != 0) begin mem[wa0] = wd0; bsy[wa0] = 1'b0; end
      if (we[1] && wa1 != 0) begin mem[wa1] = wd1; bsy[wa1] = 1'b0; end
      if (set && sa != 0) bsy[sa] = 1'b1;
    end
  endtask

  task automatic idle(input int ra0, input int ra1);
    step(1'b1, ra0, ra1, 2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 0);
  endtask

  // Monitor: compares the DUT outputs against the oldest expectation, mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("nb_data_p0", rs_data_nb[31:0],  e.nb0);
        chk("nb_data_p1", rs_data_nb[63:32], e.nb1);
        chk("by_data_p0", rs_data_by[31:0],  e.by0);
        chk("by_data_p1", rs_data_by[63:32], e.by1);
        chk("nb_busy",    32'(busy_nb),      32'(e.busy));
        chk("by_busy",    32'(busy_by),      32'(e.busy));
        chk("nb_cnt",     32'(cnt_nb),       32'(e.cnt));
        chk("by_cnt",     32'(cnt_by),       32'(e.cnt));
      end
    end
  end

  initial begin
    rst_ni = 1'b0; rs_addr = '0; rd_addr = '0; rd_data = '0; rd_we = '0; sb_set = 1'b0; sb_addr = '0;
    for (int i = 0; i < NR; i++) begin mem[i] = 32'h0; bsy[i] = 1'b0; end

    // Reset wins over writes and sets
    step(1'b0, 3, 4, 2'b11, 3, 32'h1111_1111, 4, 32'h2222_2222, 1'b1, 5);
    step(1'b0, 5, 6, 2'b11, 5, 32'h3333_3333, 6, 32'h4444_4444, 1'b1, 6);
    step(1'b1, 3, 5, 2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 0);

    // Fill r4..r31 with i-4
    for (int i = 4; i < NR; i++)
      step(1'b1, int'($urandom_range(31)), int'($urandom_range(31)), 2'b01, i, 32'(i - 4), 0, 32'h0, 1'b0, 0);
    idle(0, 16);

    // Same-cycle write/read of r5
    step(1'b1, 5, 5, 2'b01, 5, 32'hA5, 0, 32'h0, 1'b0, 0);
    idle(5, 5);

    // Write collision on r7, write to r0
    step(1'b1, 7, 7, 2'b11, 7, 32'h1, 7, 32'h2, 1'b0, 0);
    step(1'b1, 7, 0, 2'b01, 0, 32'hFFFF_FFFF, 0, 32'h0, 1'b0, 0);
    idle(7, 0);

    // Scoreboard set then clear
    step(1'b1, 9, 9, 2'b00, 0, 32'h0, 0, 32'h0, 1'b1, 9);
    step(1'b1, 9, 8, 2'b10, 0, 32'h0, 9, 32'h99, 1'b0, 0);
    idle(9, 9);

    // Set wins over same-cycle clear; set on r0 ignored
    step(1'b1, 3, 3, 2'b01, 3, 32'h33, 0, 32'h0, 1'b1, 3);
    step(1'b1, 3, 0, 2'b00, 0, 32'h0, 0, 32'h0, 1'b1, 0);
    idle(3, 0);

    // Randomised traffic, addresses biased to a small set to provoke collisions
    for (int n = 0; n < 300; n++) begin
      int ra0, ra1, wa0, wa1;
      ra0 = ($urandom_range(1) != 0) ? int'($urandom_range(7)) : int'($urandom_range(31));
      ra1 = ($urandom_range(1) != 0) ? int'($urandom_range(7)) : int'($urandom_range(31));
      wa0 = int'($urandom_range(7));
      wa1 = ($urandom_range(3) == 0) ? wa0 : int'($urandom_range(7));
      step(1'b1, ra0, ra1, 2'($urandom_range(3)), wa0, $urandom, wa1, $urandom,
           ($urandom_range(9) < 3), int'($urandom_range(7)));
    end

    // Fill the scoreboard, then assert reset mid-cycle
    for (int r = 1; r < NR; r++)
      step(1'b1, r, r - 1, 2'b00, 0, 32'h0, 0, 32'h0, 1'b1, r);
    idle(9, 31);
    step(1'b0, 9, 31, 2'b00, 0, 32'h0, 0, 32'h0, 1'b0, 0);

    repeat (3) @(posedge clk);
    n_chk++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
